// File: rtl/div_seq_if.sv
// Request/response bundle between the EXU issue logic and the sequential divider.
interface div_seq_if #(parameter int XLEN = 64);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      op;
    logic            w_mode;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid, op, w_mode, src1, src2, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, w_mode, src1, src2, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/div_seq.sv
// RV64M divide/remainder unit: restoring radix-2 on magnitudes, one quotient bit
// per cycle, then a single sign fix-up cycle. Divide-by-zero and overflow bypass CALC.
module div_seq #(
    parameter int XLEN = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    div_seq_if.slave   bus,
    output logic       busy
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, state_nx;

    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] rem_q, quo_q, dsr_q, result_q;
    logic            neg_q, neg_r, sel_rem, w_q;

    function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v, input logic w);
        return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    // Lowest set op bit wins; op==0 falls through to divu.
    logic is_signed, is_rem;
    always_comb begin
        is_signed = 1'b0;
        is_rem    = 1'b0;
        if (bus.op[0])      begin is_signed = 1'b0; is_rem = 1'b0; end
        else if (bus.op[1]) begin is_signed = 1'b1; is_rem = 1'b0; end
        else if (bus.op[2]) begin is_signed = 1'b0; is_rem = 1'b1; end
        else if (bus.op[3]) begin is_signed = 1'b1; is_rem = 1'b1; end
    end

    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, spec_res;
    logic            a_neg, b_neg, div0, ovf;
    always_comb begin
        if (bus.w_mode) begin
            a_ext = is_signed ? {{(XLEN-32){bus.src1[31]}}, bus.src1[31:0]}
                              : {{(XLEN-32){1'b0}}, bus.src1[31:0]};
            b_ext = is_signed ? {{(XLEN-32){bus.src2[31]}}, bus.src2[31:0]}
                              : {{(XLEN-32){1'b0}}, bus.src2[31:0]};
            ovf   = is_signed && bus.src1[31:0] == 32'h8000_0000 && bus.src2[31:0] == 32'hFFFF_FFFF;
        end else begin
            a_ext = bus.src1;
            b_ext = bus.src2;
            ovf   = is_signed && bus.src1 == {1'b1, {(XLEN-1){1'b0}}} && bus.src2 == '1;
        end
        a_neg = is_signed & a_ext[XLEN-1];
        b_neg = is_signed & b_ext[XLEN-1];
        a_mag = a_neg ? -a_ext : a_ext;
        b_mag = b_neg ? -b_ext : b_ext;
        div0  = (b_ext == '0);
        if (div0) spec_res = is_rem ? a_ext : '1;
        else      spec_res = is_rem ? '0 : a_ext;
    end

    logic accept;
    assign accept = (state == IDLE) && bus.in_valid && !flush;

    // One restoring step on {rem, quo}.
    logic [XLEN:0] rem_sh, diff;
    logic          take;
    assign rem_sh = {rem_q, quo_q[XLEN-1]};
    assign diff   = rem_sh - {1'b0, dsr_q};
    assign take   = !diff[XLEN];

    logic [XLEN-1:0] q_s, r_s, fix_res;
    assign q_s     = neg_q ? -quo_q : quo_q;
    assign r_s     = neg_r ? -rem_q : rem_q;
    assign fix_res = sext_w(sel_rem ? r_s : q_s, w_q);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = (div0 || ovf) ? DONE : CALC;
            CALC: if (cnt == CW'(1)) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dsr_q    <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            sel_rem  <= 1'b0;
            w_q      <= 1'b0;
        end else if (!flush) begin
            case (state)
                IDLE: if (accept) begin
                    w_q     <= bus.w_mode;
                    sel_rem <= is_rem;
                    neg_q   <= a_neg ^ b_neg;
                    neg_r   <= a_neg;
                    dsr_q   <= b_mag;
                    rem_q   <= '0;
                    // Word dividend sits in the upper half so 32 steps consume it.
                    quo_q   <= bus.w_mode ? (a_mag << 32) : a_mag;
                    cnt     <= bus.w_mode ? CW'(32) : CW'(XLEN);
                    if (div0 || ovf) result_q <= sext_w(spec_res, bus.w_mode);
                end
                CALC: begin
                    rem_q <= take ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
                    quo_q <= {quo_q[XLEN-2:0], take};
                    cnt   <= cnt - CW'(1);
                end
                FIX: result_q <= fix_res;
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_q;
    assign busy          = (state != IDLE);
endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: arithmetic, special cases, latency, flush and backpressure.
module tb_div_seq;
    localparam int XLEN = 64;

    logic clk = 1'b0;
    logic rst, flush, busy;
    int   checks = 0;
    int   failures = 0;

    div_seq_if #(.XLEN(XLEN)) bus();
    div_seq #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus), .busy(busy));

    always #5 clk = ~clk;

    localparam logic [3:0] DIVU = 4'b0001, DIV = 4'b0010, REMU = 4'b0100, REM = 4'b1000;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one request; returns just after the transfer edge with garbage on the inputs.
    task automatic issue(input logic [3:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
        checks++;
        assert (op != 4'b0) else begin
            failures++;
            $error("FAIL op_zero observed=%h expected=nonzero", op);
        end
        bus.op = op; bus.w_mode = w; bus.src1 = a; bus.src2 = b; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.src1 = {$urandom, $urandom};
        bus.src2 = {$urandom, $urandom};
        bus.op = 4'b1000;
        bus.w_mode = ~w;
    endtask

    // lat counts edges from the transfer edge (inclusive) to out_valid.
    task automatic wait_done(output int lat, output logic busy_ok);
        lat = 1;
        busy_ok = 1'b1;
        while (!bus.out_valid && lat < 200) begin
            busy_ok &= busy;
            @(posedge clk); #1;
            lat++;
        end
        busy_ok &= busy;
    endtask

    task automatic consume;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp_res, input int exp_lat);
        int   lat;
        logic bok;
        issue(op, w, a, b);
        wait_done(lat, bok);
        chk({tag, "_res"}, bus.result, exp_res);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_busy"}, {63'b0, bok}, 64'd1);
        consume;
    endtask

    initial begin
        int   lat;
        logic bok, seen, stable;

        rst = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.op = DIVU; bus.w_mode = 1'b0;
        bus.src1 = '0; bus.src2 = '0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
        chk("rst_result", bus.result, 64'd0);
        chk("rst_in_ready", {63'b0, bus.in_ready}, 64'd1);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        rst = 1'b0;

        run("divu_100_7", DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 66);
        run("div_m20_3", DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 66);
        run("rem_m20_3", REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 66);
        run("divw_ovf", DIV, 1'b1, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF,
            64'hFFFF_FFFF_8000_0000, 1);
        run("remw_ovf", REM, 1'b1, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 1);
        run("divu_by0", DIVU, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run("remu_by0", REMU, 1'b0, 64'd5, 64'd0, 64'd5, 1);
        run("remw_m7_2", REM, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34);
        run("divuw_sext", DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 34);

        // Flush 20 cycles into CALC.
        issue(DIV, 1'b0, 64'd1000, 64'd10);
        repeat (20) @(posedge clk);
        #1;
        chk("flush_pre_busy", {63'b0, busy}, 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_idle", {63'b0, bus.in_ready}, 64'd1);
        chk("flush_out_valid", {63'b0, bus.out_valid}, 64'd0);
        seen = 1'b0;
        repeat (70) begin
            @(posedge clk); #1;
            seen |= bus.out_valid;
        end
        chk("flush_no_valid", {63'b0, seen}, 64'd0);
        run("divu_9_3", DIVU, 1'b0, 64'd9, 64'd3, 64'd3, 66);

        // Backpressure in DONE with a request held pending.
        issue(DIVU, 1'b1, 64'd100, 64'd7);
        wait_done(lat, bok);
        chk("bp_res", bus.result, 64'd14);
        chk("bp_lat", 64'(lat), 64'd34);
        bus.op = REMU; bus.w_mode = 1'b0; bus.src1 = 64'd100; bus.src2 = 64'd7; bus.in_valid = 1'b1;
        stable = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            stable &= (bus.result == 64'd14) && !bus.in_ready && bus.out_valid;
        end
        chk("bp_stable", {63'b0, stable}, 64'd1);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("bp_release_idle", {63'b0, bus.in_ready}, 64'd1);
        chk("bp_release_valid", {63'b0, bus.out_valid}, 64'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("bp_pending_accepted", {63'b0, busy}, 64'd1);
        wait_done(lat, bok);
        chk("bp_pending_res", bus.result, 64'd2);
        chk("bp_pending_lat", 64'(lat), 64'd66);
        consume;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
